// File: rtl/hazard_v_pkg.sv
// Shared types for the vector register-address tracker.
// Defines the register address type, the per-stage record carried down
// the pipeline, and the all-zero bubble value used for reset and flush.
package hazard_v_pkg;

    localparam int RA_W = 4;

    typedef logic [RA_W-1:0] regaddr_t;

    typedef struct packed {
        logic     valid;
        regaddr_t ra1;
        regaddr_t ra2;
        regaddr_t wa3;
        logic     regwrite;
        logic     memtoreg;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline stage register holding a stage_t record.
// Synchronous reset and flush both load the bubble; otherwise the
// incoming record is captured on every clock edge.
import hazard_v_pkg::*;

module hazard_stage_reg (
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    input  stage_t d_in,
    output stage_t q_out
);

    stage_t stage_d;
    stage_t stage_q;

    // Pick the next record: a flush replaces whatever arrives with a bubble
    always_comb begin
        stage_d = d_in;
        if (flush) begin
            stage_d = STAGE_BUBBLE;
        end
    end

    // Stage register with synchronous reset to the bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= STAGE_BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_out = stage_q;

endmodule

// File: rtl/hazard_track_v.sv
// Register-address tracker feeding the vector hazard unit.
// Carries D-stage register addresses and write controls through E, M and W
// stage registers and produces combinational match/qualifier strobes.
// Optional statistics counters are built when HAZ_STATS_EN is defined.
import hazard_v_pkg::*;

module hazard_track_v #(
    parameter int RA_W = hazard_v_pkg::RA_W
`ifdef HAZ_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ValidD,
    input  logic [RA_W-1:0] RA1D,
    input  logic [RA_W-1:0] RA2D,
    input  logic [RA_W-1:0] WA3D,
    input  logic            RegWriteD,
    input  logic            MemtoRegD,
    input  logic            StallD,
    input  logic            FlushE,
    output logic            Match_1E_M,
    output logic            Match_1E_W,
    output logic            Match_2E_M,
    output logic            Match_2E_W,
    output logic            Match_12D_E,
    output logic            RegWriteM,
    output logic            RegWriteW,
    output logic            MemtoRegE,
    output logic [RA_W-1:0] WA3W
`ifdef HAZ_STATS_EN
    ,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FwdCnt
`endif
);

    stage_t d_rec;
    stage_t e_rec;
    stage_t m_rec;
    stage_t w_rec;
    logic   unused_fields;

    // Pack the Decode inputs into the record that enters Execute
    always_comb begin
        d_rec          = STAGE_BUBBLE;
        d_rec.valid    = ValidD;
        d_rec.ra1      = RA1D;
        d_rec.ra2      = RA2D;
        d_rec.wa3      = WA3D;
        d_rec.regwrite = RegWriteD;
        d_rec.memtoreg = MemtoRegD;
    end

    hazard_stage_reg u_stage_e (
        .clk   (clk),
        .reset (reset),
        .flush (FlushE),
        .d_in  (d_rec),
        .q_out (e_rec)
    );

    hazard_stage_reg u_stage_m (
        .clk   (clk),
        .reset (reset),
        .flush (1'b0),
        .d_in  (e_rec),
        .q_out (m_rec)
    );

    hazard_stage_reg u_stage_w (
        .clk   (clk),
        .reset (reset),
        .flush (1'b0),
        .d_in  (m_rec),
        .q_out (w_rec)
    );

    // Address compares and qualified controls; invalid stages never match
    always_comb begin
        Match_1E_M  = e_rec.valid & m_rec.valid & (e_rec.ra1 == m_rec.wa3);
        Match_2E_M  = e_rec.valid & m_rec.valid & (e_rec.ra2 == m_rec.wa3);
        Match_1E_W  = e_rec.valid & w_rec.valid & (e_rec.ra1 == w_rec.wa3);
        Match_2E_W  = e_rec.valid & w_rec.valid & (e_rec.ra2 == w_rec.wa3);
        Match_12D_E = ValidD & e_rec.valid &
                      ((RA1D == e_rec.wa3) | (RA2D == e_rec.wa3));
        RegWriteM   = m_rec.valid & m_rec.regwrite;
        RegWriteW   = w_rec.valid & w_rec.regwrite;
        MemtoRegE   = e_rec.valid & e_rec.memtoreg;
        WA3W        = w_rec.valid ? w_rec.wa3 : '0;
    end

    // Record fields that later stages carry along but nothing here reads
    assign unused_fields = ^{e_rec.regwrite, m_rec.ra1, m_rec.ra2, m_rec.memtoreg,
                             w_rec.ra1, w_rec.ra2, w_rec.memtoreg};

`ifdef HAZ_STATS_EN
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] fwd_cnt_d;
    logic [CNT_W-1:0] fwd_cnt_q;
    logic             fwd_event;

    // Saturating increments for stall cycles and qualified forwarding cycles
    always_comb begin
        fwd_event   = ((Match_1E_M | Match_2E_M) & RegWriteM) |
                      ((Match_1E_W | Match_2E_W) & RegWriteW);
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (StallD && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (fwd_event && (fwd_cnt_q != '1)) begin
            fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FwdCnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_track_v.sv
// Directed self-checking bench for hazard_track_v.
// Inputs change shortly after each rising edge; outputs are sampled 1ns later.
// Statistics checks are compiled in only when HAZ_STATS_EN is defined.
module tb_hazard_track_v;

    logic       clk;
    logic       reset;
    logic       ValidD;
    logic [3:0] RA1D;
    logic [3:0] RA2D;
    logic [3:0] WA3D;
    logic       RegWriteD;
    logic       MemtoRegD;
    logic       StallD;
    logic       FlushE;
    logic       Match_1E_M;
    logic       Match_1E_W;
    logic       Match_2E_M;
    logic       Match_2E_W;
    logic       Match_12D_E;
    logic       RegWriteM;
    logic       RegWriteW;
    logic       MemtoRegE;
    logic [3:0] WA3W;
`ifdef HAZ_STATS_EN
    logic [15:0] StallCnt;
    logic [15:0] FwdCnt;
    logic        sm_m1em, sm_m1ew, sm_m2em, sm_m2ew, sm_m12de;
    logic        sm_rwm, sm_rww, sm_m2re;
    logic [3:0]  sm_wa3w;
    logic [1:0]  sm_stall_cnt;
    logic [1:0]  sm_fwd_cnt;
`endif

    int checkCount;
    int errorCount;

    hazard_track_v #(
        .RA_W (4)
`ifdef HAZ_STATS_EN
        ,
        .CNT_W (16)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ValidD      (ValidD),
        .RA1D        (RA1D),
        .RA2D        (RA2D),
        .WA3D        (WA3D),
        .RegWriteD   (RegWriteD),
        .MemtoRegD   (MemtoRegD),
        .StallD      (StallD),
        .FlushE      (FlushE),
        .Match_1E_M  (Match_1E_M),
        .Match_1E_W  (Match_1E_W),
        .Match_2E_M  (Match_2E_M),
        .Match_2E_W  (Match_2E_W),
        .Match_12D_E (Match_12D_E),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .MemtoRegE   (MemtoRegE),
        .WA3W        (WA3W)
`ifdef HAZ_STATS_EN
        ,
        .StallCnt    (StallCnt),
        .FwdCnt      (FwdCnt)
`endif
    );

`ifdef HAZ_STATS_EN
    // Narrow-counter copy used to observe saturation
    hazard_track_v #(
        .RA_W  (4),
        .CNT_W (2)
    ) dut_small (
        .clk         (clk),
        .reset       (reset),
        .ValidD      (ValidD),
        .RA1D        (RA1D),
        .RA2D        (RA2D),
        .WA3D        (WA3D),
        .RegWriteD   (RegWriteD),
        .MemtoRegD   (MemtoRegD),
        .StallD      (StallD),
        .FlushE      (FlushE),
        .Match_1E_M  (sm_m1em),
        .Match_1E_W  (sm_m1ew),
        .Match_2E_M  (sm_m2em),
        .Match_2E_W  (sm_m2ew),
        .Match_12D_E (sm_m12de),
        .RegWriteM   (sm_rwm),
        .RegWriteW   (sm_rww),
        .MemtoRegE   (sm_m2re),
        .WA3W        (sm_wa3w),
        .StallCnt    (sm_stall_cnt),
        .FwdCnt      (sm_fwd_cnt)
    );
`endif

    // Free-running 10ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] ra1, input logic [3:0] ra2,
                                 input logic [3:0] wa3, input logic rw, input logic m2r,
                                 input logic stall, input logic flush);
        ValidD    = v;
        RA1D      = ra1;
        RA2D      = ra2;
        WA3D      = wa3;
        RegWriteD = rw;
        MemtoRegD = m2r;
        StallD    = stall;
        FlushE    = flush;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clearPipe();
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset = 1'b1;
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        tick();

        // Reset state with a valid instruction waiting in Decode
        checkOutput("rst_m1em",  Match_1E_M,  0);
        checkOutput("rst_m2ew",  Match_2E_W,  0);
        checkOutput("rst_m12de", Match_12D_E, 0);
        checkOutput("rst_rwm",   RegWriteM,   0);
        checkOutput("rst_rww",   RegWriteW,   0);
        checkOutput("rst_m2re",  MemtoRegE,   0);
        checkOutput("rst_wa3w",  WA3W,        0);

        // Release: the load enters E on the next edge and walks to W
        reset = 1'b0;
        applyStimulus(1'b1, 4'd2, 4'd3, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 4'd9, 4'd1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rel_m12de", Match_12D_E, 1);
        checkOutput("rel_m2re",  MemtoRegE,   1);
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("rel_rwm",   RegWriteM,   1);
        checkOutput("rel_m2re0", MemtoRegE,   0);
        tick();
        checkOutput("rel_rww",   RegWriteW,   1);
        checkOutput("rel_wa3w",  WA3W,        9);

        // Reset mid-pipeline discards in-flight entries
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("mid_pre_rwm", RegWriteM, 1);
        reset = 1'b1;
        tick();
        checkOutput("mid_rwm",  RegWriteM, 0);
        checkOutput("mid_wa3w", WA3W,      0);
        reset = 1'b0;
        tick();
        applyStimulus(1'b1, 4'd11, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mid_post_m12de", Match_12D_E, 1);
        clearPipe();

        // EX->EX forwarding from M
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 4'd5, 4'd1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("exex_m1em", Match_1E_M, 1);
        checkOutput("exex_rwm",  RegWriteM,  1);
        checkOutput("exex_m2em", Match_2E_M, 0);
        checkOutput("exex_m1ew", Match_1E_W, 0);
        clearPipe();

        // MEM->EX forwarding from W across a bubble
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 4'd2, 4'd7, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("memex_m2ew", Match_2E_W, 1);
        checkOutput("memex_rww",  RegWriteW,  1);
        checkOutput("memex_wa3w", WA3W,       7);
        checkOutput("memex_m2em", Match_2E_M, 0);
        checkOutput("memex_rwm",  RegWriteM,  0);
        clearPipe();

        // Load-use: detect, flush E, then forward from W
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 4'd8, 4'd3, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_m12de", Match_12D_E, 1);
        checkOutput("lu_m2re",  MemtoRegE,   1);
        applyStimulus(1'b1, 4'd8, 4'd3, 4'd10, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 4'd8, 4'd3, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_bub_m12de", Match_12D_E, 0);
        checkOutput("lu_bub_m2re",  MemtoRegE,   0);
        checkOutput("lu_bub_rwm",   RegWriteM,   1);
        tick();
        checkOutput("lu_fwd_m2ew", Match_2E_W, 1);
        checkOutput("lu_fwd_m2em", Match_2E_M, 0);
        checkOutput("lu_fwd_wa3w", WA3W,       3);
        clearPipe();

        // Bubble transparency: invalid writer to r4 never matches
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 4'd4, 4'd4, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("bub_m12de", Match_12D_E, 0);
        tick();
        checkOutput("bub_m1em", Match_1E_M, 0);
        checkOutput("bub_m2em", Match_2E_M, 0);
        checkOutput("bub_rwm",  RegWriteM,  0);
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("bub_wa3w", WA3W,      0);
        checkOutput("bub_rww",  RegWriteW, 0);
        clearPipe();

        // Register 0 is an ordinary address
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("r0_m1em", Match_1E_M, 1);
        checkOutput("r0_m2em", Match_2E_M, 1);
        clearPipe();

`ifdef HAZ_STATS_EN
        // Saturation of the 2-bit counter after 5 stall cycles
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) tick();
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("sat_small_stall", sm_stall_cnt, 3);
        checkOutput("sat_wide_stall",  StallCnt,     5);

        // Two forwarding cycles and three stall cycles from a clean reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("st_rst_stall", StallCnt, 0);
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 4'd5, 4'd1, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 4'd13, 4'd5, 4'd14, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("st_stall", StallCnt, 3);
        checkOutput("st_fwd",   FwdCnt,   2);
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
